// File: rtl/spi_pkg.sv
// Shared opcodes, command encodings and FSM states for the SPI sequencing master.
package spi_pkg;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ  = 1'b1;

  typedef enum logic [2:0] {IDLE, SEL, SHIFT, WAIT, CAPTURE, GAP} state_e;

endpackage

// File: rtl/spi_frame_shifter.sv
// Parallel-load, MSB-first frame shifter; done once all FW bits have left the register.
module spi_frame_shifter #(
  parameter int FW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          shift,
  input  logic [FW-1:0] frame,
  output logic          msb,
  output logic          done
);
  localparam int CW = $clog2(FW + 1);

  logic [FW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = frame;
      cnt_d = '0;
    end else if (shift && cnt_q != CW'(FW)) begin
      sr_d  = {sr_q[FW-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb  = sr_q[FW-1];
  assign done = (cnt_q == CW'(FW));

endmodule

// File: rtl/spi_master_seq.sv
// Byte command -> SPI frame sequencer for the SPI slave/RAM wrapper (shared clk, MSB first).
// Optional address cache: define SPI_MASTER_SEQ_ADDR_CACHE_EN.
module spi_master_seq
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int READ_LAT   = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [DATA_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);
  localparam int FW    = DATA_W + 2;
  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'((READ_LAT > 0) ? READ_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e            state_q, state_d;
  logic [1:0]        frm_q, frm_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [DATA_W-1:0] cap_q, cap_d, rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d, ss_n_q, ss_n_d, mosi_q, mosi_d;
  logic              cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic              wr_hit, rd_hit, sh_load, sh_msb, sh_done;
  logic [DATA_W-1:0] payload;

`ifdef SPI_MASTER_SEQ_ADDR_CACHE_EN
  logic [DATA_W-1:0] wa_q, wa_d, ra_q, ra_d;
  logic              wa_vld_q, wa_vld_d, ra_vld_q, ra_vld_d;

  always_comb begin
    wa_d     = wa_q;
    ra_d     = ra_q;
    wa_vld_d = wa_vld_q;
    ra_vld_d = ra_vld_q;
    if (state_q == SHIFT && sh_done) begin
      if (frm_q == WR_ADDR) begin
        wa_d     = addr_q;
        wa_vld_d = 1'b1;
      end
      if (frm_q == RD_ADDR) begin
        ra_d     = addr_q;
        ra_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_q     <= '0;
      ra_q     <= '0;
      wa_vld_q <= 1'b0;
      ra_vld_q <= 1'b0;
    end else begin
      wa_q     <= wa_d;
      ra_q     <= ra_d;
      wa_vld_q <= wa_vld_d;
      ra_vld_q <= ra_vld_d;
    end
  end

  assign wr_hit = wa_vld_q && (wa_q == cmd_addr);
  assign rd_hit = ra_vld_q && (ra_q == cmd_addr);
`else
  assign wr_hit = 1'b0;
  assign rd_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    frm_d      = frm_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cap_d      = cap_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        op_d    = cmd_op;
        addr_d  = cmd_addr;
        wdata_d = cmd_wdata;
        if (cmd_op == CMD_READ) frm_d = rd_hit ? RD_DATA : RD_ADDR;
        else                    frm_d = wr_hit ? WR_DATA : WR_ADDR;
        state_d = SEL;
      end
      SEL:   state_d = SHIFT;
      SHIFT: if (sh_done) begin
        if (frm_q == RD_DATA) state_d = (READ_LAT == 0) ? CAPTURE : WAIT;
        else                  state_d = GAP;
      end
      WAIT: if (cnt_q == LAT_LAST) state_d = CAPTURE;
      CAPTURE: begin
        cap_d = {cap_q[DATA_W-2:0], MISO};
        if (cnt_q == CAP_LAST) state_d = GAP;
      end
      GAP: if (cnt_q == GAP_LAST) begin
        // address frames have bit0 clear; the data frame that follows sets it
        if (!frm_q[0]) begin
          frm_d   = frm_q | 2'b01;
          state_d = SEL;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rsp_valid_d = (state_d == GAP) && (state_q != GAP) && frm_q[0];
    if (rsp_valid_d) rsp_data_d = (frm_q == RD_DATA) ? cap_d : '0;

    cnt_d = (state_d != state_q) ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);

    ss_n_d      = (state_d == IDLE) || (state_d == GAP);
    mosi_d      = (state_d == SHIFT) && sh_msb;
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_comb begin
    case (frm_d)
      WR_ADDR, RD_ADDR: payload = addr_d;
      WR_DATA:          payload = wdata_d;
      default:          payload = '0;
    endcase
  end

  assign sh_load = (state_d == SEL) && (state_q != SEL);

  spi_frame_shifter #(.FW(FW)) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sh_load),
    .shift (state_d == SHIFT),
    .frame ({frm_d, payload}),
    .msb   (sh_msb),
    .done  (sh_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frm_q       <= WR_ADDR;
      op_q        <= CMD_WRITE;
      addr_q      <= '0;
      wdata_q     <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frm_q       <= frm_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master_seq.sv
// Bench for spi_master_seq: behavioural SPI slave/RAM model, vector table, response scoreboard.
module tb_spi_master_seq;
  import spi_pkg::*;

`ifdef SPI_MASTER_SEQ_ADDR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0, total = 0, bad = 0, acc_cnt = 0, sent = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       c_valid = 1'b0, c_op = 1'b0;
  logic [7:0] c_addr = '0, c_wdata = '0;
  logic       c_ready, r_valid, busy, ss0, mosi0, miso0;
  logic [7:0] r_data;

  logic       c2_valid = 1'b0, c2_op = 1'b0;
  logic [7:0] c2_addr = '0, c2_wdata = '0;
  logic       c2_ready, r2_valid, busy2, ss1, mosi1, miso1;
  logic [7:0] r2_data;

  spi_master_seq #(.DATA_W(8), .READ_LAT(2), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c_valid), .cmd_ready(c_ready), .cmd_op(c_op),
    .cmd_addr(c_addr), .cmd_wdata(c_wdata), .rsp_valid(r_valid), .rsp_data(r_data),
    .busy(busy), .SS_n(ss0), .MOSI(mosi0), .MISO(miso0));

  spi_master_seq #(.DATA_W(8), .READ_LAT(3), .GAP_CYCLES(1)) dut_lat3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_op(c2_op),
    .cmd_addr(c2_addr), .cmd_wdata(c2_wdata), .rsp_valid(r2_valid), .rsp_data(r2_data),
    .busy(busy2), .SS_n(ss1), .MOSI(mosi1), .MISO(miso1));

  // slave model: one low cycle of command check, 10 frame bits, read data after ml[i] idle cycles
  logic [1:0] ssv, mosiv;
  logic [1:0] misov = '0;
  assign ssv   = {ss1, ss0};
  assign mosiv = {mosi1, mosi0};
  assign miso0 = misov[0];
  assign miso1 = misov[1];

  logic [7:0] ram [2][256];
  logic [9:0] sr [2];
  logic [7:0] wa [2], ra [2], rdat [2];
  logic       rd_on [2];
  int         pos [2];
  int         ml [2] = '{2, 3};

  typedef struct {int len; logic [9:0] frm;} frec_t;
  frec_t flog[$];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ssv[i]) begin
        if (i == 0 && pos[0] >= 11) flog.push_back('{pos[0], sr[0]});
        pos[i]   = 0;
        rd_on[i] = 1'b0;
        misov[i] <= 1'b0;
      end else begin
        pos[i]++;
        if (pos[i] >= 2 && pos[i] <= 11) sr[i] = {sr[i][8:0], mosiv[i]};
        if (pos[i] == 11) begin
          case (sr[i][9:8])
            2'b00: wa[i] = sr[i][7:0];
            2'b01: ram[i][wa[i]] = sr[i][7:0];
            2'b10: ra[i] = sr[i][7:0];
            default: begin
              rdat[i]  = ram[i][ra[i]];
              rd_on[i] = 1'b1;
            end
          endcase
        end
        if (rd_on[i] && pos[i] >= 11 + ml[i] && pos[i] <= 18 + ml[i]) begin
          int k;
          k = pos[i] - 11 - ml[i];
          misov[i] <= rdat[i][7-k];
        end else begin
          misov[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {logic [7:0] data; int due;} exp_t;
  exp_t sb[$];
  exp_t e_m;

  always @(posedge clk) if (c_valid && c_ready) acc_cnt++;

  always @(negedge clk) begin
    if (rst_n && r_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_spurious", 1, 0);
      end else begin
        e_m = sb.pop_front();
        chk("rsp_data", int'(r_data), int'(e_m.data));
        chk("rsp_cycle", cyc, e_m.due);
      end
    end
  end

  function automatic int exp_lat(input logic op, input logic hit);
    if (op == CMD_READ) return hit ? 22 : 34;
    return hit ? 12 : 24;
  endfunction

  // Called at a negedge; leaves cmd_valid high with junk while busy, returns at first ready cycle.
  task automatic send(input logic op, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] ed, input int elat, input int efr, input string nm);
    int a_cyc, n0, k;
    n0 = flog.size();
    c_op = op; c_addr = a; c_wdata = d; c_valid = 1'b1;
    k = 0;
    while (!c_ready && k < 100) begin @(negedge clk); k++; end
    if (!c_ready) begin
      chk({nm, "_ready_timeout"}, 0, 1);
      c_valid = 1'b0;
      return;
    end
    a_cyc = cyc;
    sb.push_back('{ed, a_cyc + elat});
    sent++;
    @(negedge clk);
    c_op = ~op; c_addr = ~a; c_wdata = ~d;
    k = 0;
    while (!c_ready && k < 200) begin @(negedge clk); k++; end
    chk({nm, "_lat"}, cyc - a_cyc - 1, elat);
    chk({nm, "_frames"}, flog.size() - n0, efr);
    c_valid = 1'b0;
  endtask

  typedef struct {logic op; logic [7:0] addr; logic [7:0] wdata; logic [7:0] exp; logic hit;} vec_t;
  vec_t tv [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_cyc, k;
    logic h;
    tv[0]  = '{CMD_WRITE, 8'h0F, 8'h0E, 8'h00, 1'b0};
    tv[1]  = '{CMD_READ,  8'h0F, 8'h00, 8'h0E, 1'b0};
    tv[2]  = '{CMD_WRITE, 8'h05, 8'hA5, 8'h00, 1'b0};
    tv[3]  = '{CMD_READ,  8'h05, 8'h00, 8'hA5, 1'b0};
    tv[4]  = '{CMD_WRITE, 8'h20, 8'h11, 8'h00, 1'b0};
    tv[5]  = '{CMD_WRITE, 8'h20, 8'h22, 8'h00, 1'b1};
    tv[6]  = '{CMD_READ,  8'h20, 8'h00, 8'h22, 1'b0};
    tv[7]  = '{CMD_WRITE, 8'h21, 8'h33, 8'h00, 1'b0};
    tv[8]  = '{CMD_READ,  8'h20, 8'h00, 8'h22, 1'b1};
    tv[9]  = '{CMD_WRITE, 8'hFF, 8'h80, 8'h00, 1'b0};
    tv[10] = '{CMD_READ,  8'hFF, 8'h00, 8'h80, 1'b0};
    tv[11] = '{CMD_READ,  8'h21, 8'h00, 8'h33, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_ss_n", ss0, 1);
    chk("rst_mosi", mosi0, 0);
    chk("rst_ready", c_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", r_valid, 0);
    chk("rst_rsp_data", r_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      h = tv[i].hit && CACHE;
      send(tv[i].op, tv[i].addr, tv[i].wdata, tv[i].exp, exp_lat(tv[i].op, h), h ? 1 : 2,
           $sformatf("vec%0d", i));
    end

    chk("frame0_bits", flog[0].frm, 10'b0000001111);
    chk("frame0_len", flog[0].len, 11);
    chk("frame1_bits", flog[1].frm, 10'b0100001110);
    chk("frame1_len", flog[1].len, 11);
    chk("frame2_bits", flog[2].frm, 10'b1000001111);
    chk("frame3_bits", flog[3].frm, 10'b1100000000);
    chk("frame3_len", flog[3].len, 21);

    // reset in the middle of a read-address frame
    c_op = CMD_READ; c_addr = 8'h77; c_wdata = 8'h00; c_valid = 1'b1;
    a_cyc = cyc;
    sent++;
    @(negedge clk);
    c_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ss_n", ss0, 1);
    chk("midrst_mosi", mosi0, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", c_ready, 1);
    chk("midrst_rsp_data", r_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_idle", c_ready, 1);

    send(CMD_WRITE, 8'h5A, 8'hC3, 8'h00, 24, 2, "post_rst_wr");
    send(CMD_READ,  8'h5A, 8'h00, 8'hC3, 34, 2, "post_rst_rd");

    // READ_LAT=3 instance against a slave with one extra cycle of read latency
    c2_op = CMD_WRITE; c2_addr = 8'h44; c2_wdata = 8'h3C; c2_valid = 1'b1;
    @(negedge clk);
    c2_valid = 1'b0;
    k = 0;
    while (!c2_ready && k < 100) begin @(negedge clk); k++; end
    chk("lat3_wr_done", c2_ready, 1);
    c2_op = CMD_READ; c2_valid = 1'b1;
    a_cyc = cyc;
    @(negedge clk);
    c2_valid = 1'b0;
    k = 0;
    while (!r2_valid && k < 100) begin @(negedge clk); k++; end
    chk("lat3_rsp_seen", r2_valid, 1);
    chk("lat3_rsp_data", r2_data, 8'h3C);
    chk("lat3_rsp_cycle", cyc - a_cyc, 35);

    repeat (4) @(negedge clk);
    chk("accept_count", acc_cnt, sent);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
Sequencing controller that drives the SPI slave + single-port RAM wrapper from a local command interface. Turns byte-level WRITE/READ commands into 10-bit SPI frames on SS_n/MOSI and captures read data from MISO. Shares `clk` with the wrapper: one bit per clock, MSB first, no separate SCK. Sits between on-chip host logic and the wrapper.

Parameters:
DATA_W, 8, RAM address/data width; frame width = DATA_W+2 (2 command bits + payload)
READ_LAT, 2, idle cycles between the last MOSI bit of a read-data frame and the first valid MISO bit
GAP_CYCLES, 1, cycles SS_n is held high between frames (must be >= 1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command strobe
cmd_ready  out  1  high only in IDLE; command accepted on `cmd_valid && cmd_ready`
cmd_op  in  1  0 = WRITE, 1 = READ
cmd_addr  in  DATA_W  RAM address
cmd_wdata  in  DATA_W  write data (ignored for READ)
rsp_valid  out  1  one-cycle pulse at command completion
rsp_data  out  DATA_W  read byte (0 for WRITE), held until next rsp_valid
busy  out  1  high from acceptance until return to IDLE
SS_n  out  1  slave select to wrapper, active low
MOSI  out  1  serial data to wrapper
MISO  in  1  serial data from wrapper

Behaviour:
- Reset (async) state:
  - all outputs registered
  - FSM = IDLE, `SS_n`=1, `MOSI`=0, `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_data`=0
  - frame counter and bit counter cleared
- Reset mid-frame: `SS_n` goes high immediately on the `rst_n` assertion; the partial frame is abandoned with no response.
- Frame codes:
  - 00 = write address
  - 01 = write data
  - 10 = read address
  - 11 = read data; payload is don't-care, driven 0
- WRITE sequence: frames 00+addr, then 01+wdata.
- READ sequence: frames 10+addr, then 11+0x00, then READ_LAT wait cycles, then DATA_W MISO capture cycles.
- Command latching: `cmd_op`, `cmd_addr`, `cmd_wdata` are latched at acceptance. `cmd_valid` while busy is ignored (`cmd_ready`=0).
- FSM states: IDLE -> SEL -> SHIFT -> (WAIT -> CAPTURE, read-data frame only) -> GAP -> SEL (next frame) or IDLE.
  - IDLE: `cmd_ready`=1. On accept, go to SEL.
  - SEL: `SS_n`=0, `MOSI`=0, one cycle (slave command-check cycle).
  - SHIFT: `SS_n`=0; `MOSI` = frame bit [DATA_W+1] down to [0], one per cycle, DATA_W+2 cycles.
  - WAIT: `SS_n`=0, `MOSI`=0, READ_LAT cycles.
  - CAPTURE: `SS_n`=0; MISO sampled on each rising edge into a shift register, MSB first, DATA_W cycles.
  - GAP: `SS_n`=1, `MOSI`=0, GAP_CYCLES cycles. Goes to SEL if frames remain, otherwise to IDLE.
- Response: `rsp_valid` pulses in the first cycle of the final GAP. `rsp_data` is updated in the same cycle: captured byte for READ, 0 for WRITE. `cmd_ready` rises in the cycle after the final GAP ends.
- Latency with defaults (DATA_W=8):
  - WRITE = 2*(1+10+1) = 24 cycles, acceptance to `cmd_ready` high.
  - READ = 2*(1+10) + 2 + 8 + 2 = 34 cycles.
- Back-to-back: a new command is accepted in the first IDLE cycle. No throughput loss beyond that.
- Counters: bit counter width is clog2(DATA_W+2), saturating, reloaded at each state entry.

Optional Feature:
Macro `SPI_MASTER_SEQ_ADDR_CACHE_EN`.
- Defined:
  - Last-sent write address and read address are kept in registers, each with a valid flag (cleared by reset).
  - A WRITE whose address equals the valid cached write address skips the 00 frame. WRITE latency becomes 12.
  - Same rule for READ and the 10 frame. READ latency becomes 22.
  - Cache is updated whenever an address frame completes.
- Undefined: every command always sends its address frame. No cache registers exist.

Decomposition:
- Shared package `spi_pkg` holds:
  - frame opcode constants (WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11)
  - FSM state enum (IDLE, SEL, SHIFT, WAIT, CAPTURE, GAP)
  - CMD_WRITE/CMD_READ constants
- One sub-module, `spi_frame_shifter`, is natural: parallel load of a (DATA_W+2)-bit frame, MSB-first shift-out, done flag. The top holds the FSM, capture register and response logic.

Test Plan:
- WRITE addr=0x0F, wdata=0x0E:
  - MOSI frames 0000001111 then 0100001110
  - `SS_n` low 11 cycles, high 1 cycle, per frame
  - `rsp_valid` at cycle 23, `rsp_data`=0
  - RAM[15]=0x0E in the wrapper
- READ addr=0x0F after that write:
  - frames 1000001111, 1100000000
  - `rsp_data`=0x0E, `rsp_valid` single pulse, total 34 cycles
- Back-to-back: WRITE 0x05/0xA5 then READ 0x05 issued on the first `cmd_ready`; `rsp_data`=0xA5. `cmd_valid` held during busy causes no extra accepts.
- Reset mid-SHIFT of a READ (after bit 4):
  - `SS_n`=1, `MOSI`=0, `busy`=0, `cmd_ready`=1 immediately
  - no `rsp_valid`
  - next WRITE completes normally
- READ_LAT=3 override with a MISO model delayed by one extra cycle: captured byte still correct (0x3C).
- With `SPI_MASTER_SEQ_ADDR_CACHE_EN`: two WRITEs to 0x20 (0x11, 0x22) -> second has no 00 frame and 12-cycle latency; READ 0x20 returns 0x22. A write to 0x21 re-sends its address frame.
